kernel_kcore_start_fifo_v2: RTL

- Parametrised successor to the kernel's start/stream FIFOs.
- Shift-register FIFO with arbitrary (non-power-of-2) depth and an occupancy count output.
- Registered almost-full/almost-empty thresholds, a synchronous flush, and an optional registered-output (prefetch) mode.
- Sits between dataflow processes in kernel_kcore, carrying start tokens or narrow data words under empty_n/full_n handshakes.

---
 rtl/kernel_kcore_start_fifo_v2.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/kernel_kcore_start_fifo_v2.sv
// Shift-register FIFO with occupancy count, registered threshold flags, synchronous flush and
// optional prefetch output register (OUT_REG=1). Sticky error flags: define KCORE_FIFO_ERR_FLAGS_EN.
module kernel_kcore_start_fifo_v2 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 5,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_flush,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH+1:0] if_num_data,
    output logic                  if_almost_full,
`ifdef KCORE_FIFO_ERR_FLAGS_EN
    output logic                  if_almost_empty,
    output logic                  if_ovf_err,
    output logic                  if_udf_err
`else
    output logic                  if_almost_empty
`endif
);

    localparam int CAP = DEPTH + OUT_REG;
    localparam int CW  = ADDR_WIDTH + 2;

    if (DEPTH < 2) begin : g_bad_depth
        $error("kernel_kcore_start_fifo_v2: DEPTH must be >= 2");
    end
    if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_addr
        $error("kernel_kcore_start_fifo_v2: ADDR_WIDTH too small for DEPTH");
    end
    if (AF_MARGIN >= CAP) begin : g_bad_af
        $error("kernel_kcore_start_fifo_v2: AF_MARGIN must be < CAP");
    end
    if (AE_MARGIN >= CAP) begin : g_bad_ae
        $error("kernel_kcore_start_fifo_v2: AE_MARGIN must be < CAP");
    end

    logic [DATA_WIDTH-1:0] srl [DEPTH];
    logic [CW-1:0]         count_reg, count_next;
    logic [CW-1:0]         num_reg, num_next;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr, rd, shift, empty_n_next;
    logic                  full_n_reg, empty_n_reg, af_reg, ae_reg;

    assign wr      = if_write & if_write_ce & full_n_reg;
    assign rd      = if_read & if_read_ce & empty_n_reg;
    // Oldest word sits at count-1; newest always enters at index 0.
    assign rd_addr = (count_reg == '0) ? '0 : ADDR_WIDTH'(count_reg - CW'(1));

    always_ff @(posedge clk) begin
        if (shift) begin
            srl[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) srl[i] <= srl[i-1];
        end
    end

    if (OUT_REG == 0) begin : g_comb_out
        always_comb begin
            shift      = wr;
            count_next = count_reg;
            if (wr && !rd)      count_next = count_reg + CW'(1);
            else if (rd && !wr) count_next = count_reg - CW'(1);
            if (if_flush)       count_next = '0;
            num_next     = count_next;
            empty_n_next = (count_next != '0);
        end
        assign if_dout = srl[rd_addr];
    end else begin : g_reg_out
        logic                  ov_reg, ov_next, pop_ok, load, bypass;
        logic [DATA_WIDTH-1:0] dout_reg, dout_next;

        always_comb begin
            pop_ok     = !ov_reg || rd;
            load       = pop_ok && (count_reg != '0);
            // An empty SRL lets a write go straight to the output register.
            bypass     = pop_ok && (count_reg == '0) && wr;
            shift      = wr && !bypass;
            count_next = count_reg + CW'(shift) - CW'(load);
            ov_next    = pop_ok ? (load || bypass) : 1'b1;
            dout_next  = dout_reg;
            if (load)        dout_next = srl[rd_addr];
            else if (bypass) dout_next = if_din;
            if (if_flush) begin
                count_next = '0;
                ov_next    = 1'b0;
            end
            num_next     = count_next + CW'(ov_next);
            empty_n_next = ov_next;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) ov_reg <= 1'b0;
            else          ov_reg <= ov_next;
        end

        always_ff @(posedge clk) dout_reg <= dout_next;

        assign if_dout = dout_reg;
    end

    // Status flags are registered from next-state values so they track the count exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg   <= '0;
            num_reg     <= '0;
            full_n_reg  <= 1'b1;
            empty_n_reg <= 1'b0;
            af_reg      <= 1'b0;
            ae_reg      <= 1'b1;
        end else begin
            count_reg   <= count_next;
            num_reg     <= num_next;
            full_n_reg  <= (count_next != CW'(DEPTH));
            empty_n_reg <= empty_n_next;
            af_reg      <= (num_next >= CW'(CAP - AF_MARGIN));
            ae_reg      <= (num_next <= CW'(AE_MARGIN));
        end
    end

    assign if_full_n       = full_n_reg;
    assign if_empty_n      = empty_n_reg;
    assign if_num_data     = num_reg;
    assign if_almost_full  = af_reg;
    assign if_almost_empty = ae_reg;

`ifdef KCORE_FIFO_ERR_FLAGS_EN
    logic ovf_reg, udf_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else if (if_flush) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            if (if_write && if_write_ce && !full_n_reg) ovf_reg <= 1'b1;
            if (if_read && if_read_ce && !empty_n_reg)  udf_reg <= 1'b1;
        end
    end

    assign if_ovf_err = ovf_reg;
    assign if_udf_err = udf_reg;
`endif

endmodule
